// File: rtl/instr_sequencer.sv
// Step counter and 16-bit instruction register for the 8-bit CPU core.
// The step counter freezes while a memory-using step waits on the bus.
module instr_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STATE_WIDTH  = 3,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned FUNC_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   memRdata,
  input  logic                    memReady,
  input  logic                    memAccess,
  input  logic                    resetState,
  input  logic                    instrRegLowWriteEn,
  input  logic                    instrRegHighWriteEn,
  output logic [STATE_WIDTH-1:0]  state,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [FUNC_WIDTH-1:0]   func,
  output logic [3:0]              rd,
  output logic [3:0]              rs,
  output logic [DATA_WIDTH-1:0]   imm8,
  output logic                    stall,
  output logic                    seqFault,
  output logic [COUNT_WIDTH-1:0]  instrCount
);

  localparam int unsigned InstrWidth = 2 * DATA_WIDTH;
  localparam logic [STATE_WIDTH-1:0] StateMax = {STATE_WIDTH{1'b1}};

  logic [STATE_WIDTH-1:0] stateQ, stateD;
  logic [InstrWidth-1:0]  instrQ, instrD;
  logic [COUNT_WIDTH-1:0] countQ, countD;
  logic                   faultQ, faultD;
  logic                   memStep;
  logic                   advance;

  always_comb begin
    memStep = instrRegLowWriteEn | instrRegHighWriteEn | memAccess;
    stall   = memStep & ~memReady;
    advance = ~stall;

    stateD = stateQ;
    instrD = instrQ;
    countD = countQ;
    faultD = faultQ;

    if (advance) begin
      if (resetState) begin
        stateD = '0;
        countD = countQ + 1'b1;
      end else if (stateQ == StateMax) begin
        // Running off the end of the step space means the decoder never retired.
        stateD = '0;
        faultD = 1'b1;
      end else begin
        stateD = stateQ + 1'b1;
      end
    end

    if (instrRegLowWriteEn && memReady) begin
      instrD[DATA_WIDTH-1:0] = memRdata;
    end
    if (instrRegHighWriteEn && memReady) begin
      instrD[InstrWidth-1:DATA_WIDTH] = memRdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= '0;
      instrQ <= '0;
      countQ <= '0;
      faultQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      instrQ <= instrD;
      countQ <= countD;
      faultQ <= faultD;
    end
  end

  assign state      = stateQ;
  assign seqFault   = faultQ;
  assign instrCount = countQ;
  assign opcode     = instrQ[InstrWidth-1 -: OPCODE_WIDTH];
  assign rd         = instrQ[InstrWidth-OPCODE_WIDTH-1 -: 4];
  assign rs         = instrQ[FUNC_WIDTH +: 4];
  assign func       = instrQ[FUNC_WIDTH-1:0];
  assign imm8       = instrQ[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  memRdata;
  logic        memReady;
  logic        memAccess;
  logic        resetState;
  logic        lowEn;
  logic        highEn;
  logic [2:0]  state;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [7:0]  imm8;
  logic        stall;
  logic        seqFault;
  logic [15:0] instrCount;

  typedef struct {
    string       name;
    logic [2:0]  state;
    logic        stall;
    logic [15:0] instr;
    logic [15:0] count;
    logic        fault;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  instr_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .memRdata            (memRdata),
    .memReady            (memReady),
    .memAccess           (memAccess),
    .resetState          (resetState),
    .instrRegLowWriteEn  (lowEn),
    .instrRegHighWriteEn (highEn),
    .state               (state),
    .opcode              (opcode),
    .func                (func),
    .rd                  (rd),
    .rs                  (rs),
    .imm8                (imm8),
    .stall               (stall),
    .seqFault            (seqFault),
    .instrCount          (instrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: registered outputs have settled half a cycle after the edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      logic [15:0] fields;
      e = expQ.pop_front();
      fields = {opcode, rd, rs, func};
      chk({e.name, ".state"}, {13'd0, state}, {13'd0, e.state});
      chk({e.name, ".stall"}, {15'd0, stall}, {15'd0, e.stall});
      chk({e.name, ".fields"}, fields, e.instr);
      chk({e.name, ".imm8"}, {8'd0, imm8}, {8'd0, e.instr[7:0]});
      chk({e.name, ".count"}, instrCount, e.count);
      chk({e.name, ".fault"}, {15'd0, seqFault}, {15'd0, e.fault});
    end
  end

  task automatic push(input string nm, input logic [2:0] st, input logic sl,
                      input logic [15:0] ins, input logic [15:0] cnt, input logic flt);
    exp_t e;
    e.name  = nm;
    e.state = st;
    e.stall = sl;
    e.instr = ins;
    e.count = cnt;
    e.fault = flt;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs, queue the outputs expected before the next edge.
  task automatic cyc(input string nm, input logic lo, input logic hi, input logic acc,
                     input logic rdy, input logic rsS, input logic [7:0] dat,
                     input logic [2:0] eSt, input logic eSl, input logic [15:0] eIns,
                     input logic [15:0] eCnt, input logic eFlt);
    lowEn      = lo;
    highEn     = hi;
    memAccess  = acc;
    memReady   = rdy;
    resetState = rsS;
    memRdata   = dat;
    push(nm, eSt, eSl, eIns, eCnt, eFlt);
    @(posedge clk);
    #1;
  endtask

  // Asserted between edges; outputs must clear before the next edge.
  task automatic doReset(input string nm);
    lowEn      = 1'b0;
    highEn     = 1'b0;
    memAccess  = 1'b0;
    memReady   = 1'b0;
    resetState = 1'b0;
    memRdata   = 8'h00;
    rst_n      = 1'b0;
    push(nm, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    lowEn      = 1'b0;
    highEn     = 1'b0;
    memAccess  = 1'b0;
    memReady   = 1'b0;
    resetState = 1'b0;
    memRdata   = 8'h00;
    @(posedge clk);
    #1;
    doReset("reset0");

    // name lo hi acc rdy rsS data | state stall instr count fault
    cyc("fetchLo",  1, 0, 0, 1, 0, 8'h34, 3'd0, 0, 16'h0000, 16'd0, 0);
    cyc("fetchHi",  0, 1, 0, 1, 0, 8'h12, 3'd1, 0, 16'h0034, 16'd0, 0);
    cyc("exec",     0, 0, 0, 1, 1, 8'h00, 3'd2, 0, 16'h1234, 16'd0, 0);
    cyc("waitLo",   1, 0, 0, 1, 0, 8'h78, 3'd0, 0, 16'h1234, 16'd1, 0);
    cyc("waitHi0",  0, 1, 0, 0, 0, 8'h56, 3'd1, 1, 16'h1278, 16'd1, 0);
    cyc("waitHi1",  0, 1, 0, 0, 1, 8'h56, 3'd1, 1, 16'h1278, 16'd1, 0);
    cyc("waitHiOk", 0, 1, 0, 1, 0, 8'h56, 3'd1, 0, 16'h1278, 16'd1, 0);
    cyc("waitExec", 0, 0, 0, 1, 1, 8'h00, 3'd2, 0, 16'h5678, 16'd1, 0);

    doReset("reset1");
    for (int i = 0; i < 8; i++) begin
      cyc("overrun", 0, 0, 0, 1, 0, 8'h00, 3'(i), 0, 16'h0000, 16'd0, 0);
    end
    cyc("overWrap", 0, 0, 0, 1, 0, 8'h00, 3'd0, 0, 16'h0000, 16'd0, 1);
    cyc("toStep2",  0, 0, 0, 1, 0, 8'h00, 3'd1, 0, 16'h0000, 16'd0, 1);
    cyc("toStep3",  0, 0, 0, 1, 0, 8'h00, 3'd2, 0, 16'h0000, 16'd0, 1);
    cyc("toStep4",  0, 0, 0, 1, 0, 8'h00, 3'd3, 0, 16'h0000, 16'd0, 1);
    cyc("stallRst", 0, 0, 1, 0, 1, 8'h00, 3'd4, 1, 16'h0000, 16'd0, 1);
    cyc("stallRdy", 0, 0, 1, 1, 1, 8'h00, 3'd4, 0, 16'h0000, 16'd0, 1);

    // Preload the counter to 0xFFFF with one-step instructions.
    resetState = 1'b1;
    memAccess  = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    cyc("preWrap",  0, 0, 0, 1, 1, 8'h00, 3'd0, 0, 16'h0000, 16'hFFFF, 1);
    cyc("wrapLo",   1, 0, 0, 1, 0, 8'hC3, 3'd0, 0, 16'h0000, 16'h0000, 1);
    cyc("asyncHi",  0, 1, 0, 1, 0, 8'hA5, 3'd1, 0, 16'h00C3, 16'h0000, 1);
    cyc("asyncS2",  0, 0, 0, 1, 0, 8'h00, 3'd2, 0, 16'hA5C3, 16'h0000, 1);
    cyc("asyncS3",  0, 0, 0, 1, 0, 8'h00, 3'd3, 0, 16'hA5C3, 16'h0000, 1);
    doReset("asyncRst");
    cyc("bothEn",   1, 1, 0, 1, 0, 8'h9E, 3'd0, 0, 16'h0000, 16'h0000, 0);
    cyc("bothChk",  0, 0, 0, 1, 0, 8'h00, 3'd1, 0, 16'h9E9E, 16'h0000, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
